fft_butterfly: RTL and testbench

- Radix-2 DIT butterfly stage, directly downstream of fft_mult_comp.
- Takes data point A and the rotated product B·W from the complex multiplier.
- Produces X = A + B·W and Y = A − B·W, with optional divide-by-2 scaling per stage.
- Delays A internally to match the multiplier latency, tracks overflow, and passes a valid strobe through a fixed pipeline.

---
 rtl/fft_butterfly.sv | 120 ++++++++++++
 tb/tb_fft_butterfly.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: X = A + B*W, Y = A - B*W with optional per-stage halving.
// A is delayed to line up with the multiplier output; saturation sets a sticky flag.
module fft_butterfly #(
    parameter int D_BIT    = 17,
    parameter int MULT_LAT = 1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iVALID,
    input  logic signed [D_BIT-1:0] iA_RE,
    input  logic signed [D_BIT-1:0] iA_IM,
    input  logic signed [D_BIT-1:0] iBW_RE,
    input  logic signed [D_BIT-1:0] iBW_IM,
    input  logic                    iSCALE,
    input  logic                    iCLR_OVF,
    output logic                    oVALID,
    output logic signed [D_BIT-1:0] oX_RE,
    output logic signed [D_BIT-1:0] oX_IM,
    output logic signed [D_BIT-1:0] oY_RE,
    output logic signed [D_BIT-1:0] oY_IM,
    output logic                    oOVF
);

    localparam int E = D_BIT + 1;
    localparam int R = D_BIT + 2;
    localparam logic signed [D_BIT-1:0] P_MAX = {1'b0, {(D_BIT-1){1'b1}}};
    localparam logic signed [D_BIT-1:0] P_MIN = {1'b1, {(D_BIT-1){1'b0}}};

    // Handshake: iVALID qualifies A/iSCALE this cycle and iBW_* MULT_LAT cycles later;
    // oVALID qualifies oX_*/oY_* for exactly one cycle. No backpressure exists.
    logic signed [D_BIT-1:0] r_a_re [MULT_LAT];
    logic signed [D_BIT-1:0] r_a_im [MULT_LAT];
    logic [MULT_LAT-1:0]     r_valid;
    logic [MULT_LAT-1:0]     r_scale;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                r_a_re[i] <= '0;
                r_a_im[i] <= '0;
            end
            r_valid <= '0;
            r_scale <= '0;
        end else begin
            r_a_re[0]  <= iA_RE;
            r_a_im[0]  <= iA_IM;
            r_valid[0] <= iVALID;
            r_scale[0] <= iSCALE;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_a_re[i]  <= r_a_re[i-1];
                r_a_im[i]  <= r_a_im[i-1];
                r_valid[i] <= r_valid[i-1];
                r_scale[i] <= r_scale[i-1];
            end
        end
    end

    // Returns {overflow_event, result}. The halved path rounds half-up; the single
    // corner (2^(D_BIT-1)-1) - (-2^(D_BIT-1)) would round to 2^(D_BIT-1), so it is
    // pinned to the positive maximum without raising an overflow event.
    function automatic logic [D_BIT:0] f_proc(input logic signed [E-1:0] s, input logic sc);
        logic signed [R-1:0] v_rnd;
        logic signed [R-1:0] v_half;
        logic [D_BIT:0]      v_out;
        v_rnd  = R'(s) + R'(1);
        v_half = v_rnd >>> 1;
        if (sc) begin
            if (v_half > R'(P_MAX)) v_out = {1'b0, P_MAX};
            else                    v_out = {1'b0, v_half[D_BIT-1:0]};
        end else begin
            if (s > E'(P_MAX))      v_out = {1'b1, P_MAX};
            else if (s < E'(P_MIN)) v_out = {1'b1, P_MIN};
            else                    v_out = {1'b0, s[D_BIT-1:0]};
        end
        return v_out;
    endfunction

    logic                    w_dv;
    logic                    w_ds;
    logic signed [E-1:0]     w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic [D_BIT:0]          w_x_re, w_x_im, w_y_re, w_y_im;
    logic                    w_ovf;

    always_comb begin
        w_dv     = r_valid[MULT_LAT-1];
        w_ds     = r_scale[MULT_LAT-1];
        w_sum_re = E'(r_a_re[MULT_LAT-1]) + E'(iBW_RE);
        w_sum_im = E'(r_a_im[MULT_LAT-1]) + E'(iBW_IM);
        w_dif_re = E'(r_a_re[MULT_LAT-1]) - E'(iBW_RE);
        w_dif_im = E'(r_a_im[MULT_LAT-1]) - E'(iBW_IM);
        w_x_re   = f_proc(w_sum_re, w_ds);
        w_x_im   = f_proc(w_sum_im, w_ds);
        w_y_re   = f_proc(w_dif_re, w_ds);
        w_y_im   = f_proc(w_dif_im, w_ds);
        w_ovf    = w_x_re[D_BIT] | w_x_im[D_BIT] | w_y_re[D_BIT] | w_y_im[D_BIT];
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oVALID <= 1'b0;
            oX_RE  <= '0;
            oX_IM  <= '0;
            oY_RE  <= '0;
            oY_IM  <= '0;
            oOVF   <= 1'b0;
        end else begin
            oVALID <= w_dv;
            if (w_dv) begin
                oX_RE <= w_x_re[D_BIT-1:0];
                oX_IM <= w_x_im[D_BIT-1:0];
                oY_RE <= w_y_re[D_BIT-1:0];
                oY_IM <= w_y_im[D_BIT-1:0];
            end
            // A fresh overflow outranks a clear arriving in the same cycle.
            if (w_dv && w_ovf) oOVF <= 1'b1;
            else if (iCLR_OVF) oOVF <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly (D_BIT=17, MULT_LAT=1) with a queue-based scoreboard.
module tb_fft_butterfly;

    localparam int D = 17;

    logic                iCLK = 1'b0;
    logic                iRESET;
    logic                iVALID;
    logic signed [D-1:0] iA_RE, iA_IM, iBW_RE, iBW_IM;
    logic                iSCALE, iCLR_OVF;
    logic                oVALID;
    logic signed [D-1:0] oX_RE, oX_IM, oY_RE, oY_IM;
    logic                oOVF;

    fft_butterfly #(.D_BIT(D), .MULT_LAT(1)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID),
        .iA_RE(iA_RE), .iA_IM(iA_IM), .iBW_RE(iBW_RE), .iBW_IM(iBW_IM),
        .iSCALE(iSCALE), .iCLR_OVF(iCLR_OVF),
        .oVALID(oVALID), .oX_RE(oX_RE), .oX_IM(oX_IM), .oY_RE(oY_RE), .oY_IM(oY_IM),
        .oOVF(oOVF)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int xr, xi, yr, yi;
        int ovf;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   pend_re = 0, pend_im = 0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc_n);
        end
    endtask

    // One clock of stimulus; B*W of the vector issued here is applied next cycle.
    task automatic cyc(input logic v, input int ar, input int ai, input int br, input int bi,
                       input logic sc, input logic clr);
        @(posedge iCLK);
        #1;
        cyc_n++;
        iVALID   = v;
        iA_RE    = D'(ar);
        iA_IM    = D'(ai);
        iSCALE   = sc;
        iCLR_OVF = clr;
        iBW_RE   = D'(pend_re);
        iBW_IM   = D'(pend_im);
        pend_re  = br;
        pend_im  = bi;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input int xr, input int xi, input int yr, input int yi, input int ovf);
        exp_t e;
        e.xr = xr; e.xi = xi; e.yr = yr; e.yi = yi; e.ovf = ovf;
        e.due = cyc_n + 2;
        exp_q.push_back(e);
    endtask

    initial begin
        iRESET = 1'b0; iVALID = 1'b0; iA_RE = '0; iA_IM = '0;
        iBW_RE = '0; iBW_IM = '0; iSCALE = 1'b0; iCLR_OVF = 1'b0;

        fork
            forever begin
                @(negedge iCLK);
                while (exp_q.size() > 0 && exp_q[0].due < cyc_n) begin
                    chk("missing_result", 0, 1);
                    void'(exp_q.pop_front());
                end
                if (oVALID) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("latency", cyc_n, e.due);
                        chk("x_re", int'(oX_RE), e.xr);
                        chk("x_im", int'(oX_IM), e.xi);
                        chk("y_re", int'(oY_RE), e.yr);
                        chk("y_im", int'(oY_IM), e.yi);
                        chk("ovf", int'(oOVF), e.ovf);
                    end
                end
            end
        join_none

        // Reset state
        idle(2);
        @(negedge iCLK);
        chk("rst_valid", int'(oVALID), 0);
        chk("rst_x_re", int'(oX_RE), 0);
        chk("rst_y_im", int'(oY_IM), 0);
        chk("rst_ovf", int'(oOVF), 0);
        #2 iRESET = 1'b1;
        idle(2);

        // Basic add/sub, then hold
        cyc(1'b1, 1000, -2000, 300, 400, 1'b0, 1'b0);
        push_exp(1300, -1600, 700, -2400, 0);
        idle(3);
        @(negedge iCLK);
        chk("hold_valid", int'(oVALID), 0);
        chk("hold_x_re", int'(oX_RE), 1300);
        chk("hold_y_im", int'(oY_IM), -2400);

        // Scaled with round-half-up, including extreme operands
        cyc(1'b1, 3, -3, 0, 0, 1'b1, 1'b0);
        push_exp(2, -1, 2, -1, 0);
        cyc(1'b1, 65535, 65535, 65535, -65536, 1'b1, 1'b0);
        push_exp(65535, 0, 0, 65535, 0);
        idle(3);

        // Saturation in both directions, sticky across clean results
        cyc(1'b1, 60000, -60000, 10000, 10000, 1'b0, 1'b0);
        push_exp(65535, -50000, 50000, -65536, 1);
        idle(3);

        // Back-to-back, gap, one more
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, k, 0, k, k, 1'b0, 1'b0);
            push_exp(2 * k, k, 0, -k, 1);
        end
        idle(2);
        cyc(1'b1, 5, 0, 5, 5, 1'b0, 1'b0);
        push_exp(10, 5, 0, -5, 1);
        idle(3);

        // Clear alone, then clear colliding with a saturating result
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        idle(1);
        @(negedge iCLK);
        chk("ovf_cleared", int'(oOVF), 0);
        cyc(1'b1, 60000, -60000, 10000, 10000, 1'b0, 1'b0);
        push_exp(65535, -50000, 50000, -65536, 1);
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset with a valid mid-pipeline
        cyc(1'b1, 1000, -2000, 300, 400, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
        #2 iRESET = 1'b0;
        #1;
        chk("arst_valid", int'(oVALID), 0);
        chk("arst_x_re", int'(oX_RE), 0);
        chk("arst_x_im", int'(oX_IM), 0);
        chk("arst_y_re", int'(oY_RE), 0);
        chk("arst_ovf", int'(oOVF), 0);
        idle(2);
        #2 iRESET = 1'b1;
        idle(4);
        cyc(1'b1, 1000, -2000, 300, 400, 1'b0, 1'b0);
        push_exp(1300, -1600, 700, -2400, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
        idle(1);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
